// File: rtl/fifo_rd_stream_pkg.sv
//------------------------------------------------------------------------------
// fifo_rd_stream_pkg
//
// Shared definitions for the read-side drain engine of the async FIFO.
//
// Contents
//    FIFO_DSIZE      default data width, shared with the FIFO itself
//    RD_CW           default width of the delivered-word counter
//    rd_state_t      drain FSM state encoding (EMPTY/ONE/TWO/FLUSH)
//    state_for_cnt   maps an output-buffer occupancy to its normal state
//------------------------------------------------------------------------------
package fifo_rd_stream_pkg;

   localparam int FIFO_DSIZE = 8;
   localparam int RD_CW      = 16;

   // The first three encodings equal the output-buffer occupancy, so a
   // debug probe of the state reads directly as "words held".
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2,
      ST_FLUSH = 2'd3
   } rd_state_t;

   // Occupancy 3 cannot happen with a 2-entry buffer; it saturates to TWO so
   // the mapping is total.
   function automatic rd_state_t state_for_cnt(input logic [1:0] i_cnt);
      rd_state_t v_state;
      case (i_cnt)
         2'd0:    v_state = ST_EMPTY;
         2'd1:    v_state = ST_ONE;
         default: v_state = ST_TWO;
      endcase
      return v_state;
   endfunction

endpackage

// File: rtl/rd_skid_buf.sv
//------------------------------------------------------------------------------
// rd_skid_buf
//
// Two-entry registered output buffer sitting between the FIFO read port and
// the outgoing stream. Entry 0 (head) drives the stream data directly, so the
// stream data is always a flop output.
//
// Ports
//    i_clk     clock
//    i_rst_n   asynchronous active-low reset
//    i_push    write i_data at the tail
//    i_pop     drop the head; the tail (if any) moves up to the head
//    i_clear   discard all entries (takes priority over push/pop)
//    i_data    word to push
//    o_head    head entry (registered)
//    o_count   number of valid entries, 0..2
//
// Valid/ready contract on the side using this buffer: i_pop is only raised
// while o_count!=0, i_push only while o_count<2 or together with i_pop.
// Requests outside that contract are ignored rather than corrupting state.
//------------------------------------------------------------------------------
module rd_skid_buf
   import fifo_rd_stream_pkg::*;
#(
   parameter int DSIZE = FIFO_DSIZE
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic             i_clear,
   input  logic [DSIZE-1:0] i_data,
   output logic [DSIZE-1:0] o_head,
   output logic [1:0]       o_count
);

   logic [DSIZE-1:0] r_head;
   logic [DSIZE-1:0] r_tail;
   logic [1:0]       r_count;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= 2'd0;
      end else if (i_clear) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= 2'd0;
      end else begin
         case ({i_push, i_pop})
            2'b10: begin
               if (r_count == 2'd0) begin
                  r_head  <= i_data;
                  r_count <= 2'd1;
               end else if (r_count == 2'd1) begin
                  r_tail  <= i_data;
                  r_count <= 2'd2;
               end
            end
            2'b01: begin
               if (r_count != 2'd0) begin
                  r_head  <= r_tail;
                  r_count <= r_count - 2'd1;
               end
            end
            2'b11: begin
               // Occupancy is unchanged; with two entries the tail advances
               // to the head and the new word becomes the tail, with one
               // entry the new word replaces the head directly.
               if (r_count == 2'd2) begin
                  r_head <= r_tail;
                  r_tail <= i_data;
               end else if (r_count == 2'd1) begin
                  r_head <= i_data;
               end else begin
                  r_head  <= i_data;
                  r_count <= 2'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign o_head  = r_head;
   assign o_count = r_count;

endmodule

// File: rtl/fifo_rd_stream.sv
//------------------------------------------------------------------------------
// fifo_rd_stream
//
// Read-domain drain engine for the async FIFO. Pops words from the FIFO read
// port into a 2-entry registered buffer and presents them as a valid/ready
// stream. A flush discards buffered words and drains the FIFO until empty.
// Completed stream handshakes are counted.
//
// Ports
//    rclk        read-domain clock
//    rrst_n      asynchronous active-low reset
//    rdata       FIFO read data, valid whenever rempty=0
//    rempty      FIFO empty flag (synchronous to rclk)
//    rinc        FIFO pop strobe, one word consumed per edge with rinc=1
//    m_data      stream data (registered buffer head)
//    m_valid     stream valid (registered)
//    m_ready     stream ready from consumer
//    flush       flush request, level-sampled at rclk
//    flush_busy  high while in the FLUSH state
//    rd_count    completed handshakes, wraps mod 2^CW
//    dbg_state   current FSM state, for probes and checkers
//
// Handshake semantics: a word transfers on every rclk edge where
// m_valid && m_ready; m_data/m_valid never change while m_valid && !m_ready
// unless flush or reset removes the word. On the FIFO side a word is taken
// on every edge where rinc=1, and rinc is never raised while rempty=1.
//------------------------------------------------------------------------------
module fifo_rd_stream
   import fifo_rd_stream_pkg::*;
#(
   parameter int DSIZE = FIFO_DSIZE,
   parameter int CW    = RD_CW
) (
   input  logic             rclk,
   input  logic             rrst_n,
   input  logic [DSIZE-1:0] rdata,
   input  logic             rempty,
   output logic             rinc,
   output logic [DSIZE-1:0] m_data,
   output logic             m_valid,
   input  logic             m_ready,
   input  logic             flush,
   output logic             flush_busy,
   output logic [CW-1:0]    rd_count,
   output logic [1:0]       dbg_state
);

   localparam logic [CW-1:0] ONE_CW = {{(CW-1){1'b0}}, 1'b1};

   rd_state_t        r_state;
   logic             r_run;
   logic             r_m_valid;
   logic             r_flush_busy;
   logic [CW-1:0]    r_rd_count;

   logic [1:0]       w_cnt;
   logic [DSIZE-1:0] w_head;
   logic             w_in_flush;
   logic             w_rinc;
   logic             w_push;
   logic             w_pop;
   logic [1:0]       w_cnt_next;
   rd_state_t        w_state_next;

   assign w_in_flush = (r_state == ST_FLUSH);

   // r_run holds rinc low through reset and for the first edge after release,
   // so the pop strobe only depends on flops, rempty and flush.
   // Outside a flush the buffer only requests while it has room; during a
   // flush every available word is taken and thrown away. m_ready is
   // deliberately not part of this term.
   assign w_rinc = r_run && !rempty && (flush || w_in_flush || (w_cnt != 2'd2));

   // Words popped under flush (requested or ongoing) are discarded.
   assign w_push = w_rinc && !flush && !w_in_flush;
   assign w_pop  = r_m_valid && m_ready;

   always_comb begin
      w_cnt_next = w_cnt;
      if (flush) begin
         w_cnt_next = 2'd0;
      end else begin
         case ({w_push, w_pop})
            2'b10:   w_cnt_next = w_cnt + 2'd1;
            2'b01:   w_cnt_next = w_cnt - 2'd1;
            default: w_cnt_next = w_cnt;
         endcase
      end
   end

   always_comb begin
      w_state_next = state_for_cnt(w_cnt_next);
      if (flush) begin
         w_state_next = ST_FLUSH;
      end else if (w_in_flush) begin
         w_state_next = rempty ? ST_EMPTY : ST_FLUSH;
      end
   end

   rd_skid_buf #(
      .DSIZE (DSIZE)
   ) u_buf (
      .i_clk   (rclk),
      .i_rst_n (rrst_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_clear (flush),
      .i_data  (rdata),
      .o_head  (w_head),
      .o_count (w_cnt)
   );

   // FSM with registered outputs. A handshake on the same edge as a flush
   // still counts: the consumer has taken that word.
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         r_state      <= ST_EMPTY;
         r_run        <= 1'b0;
         r_m_valid    <= 1'b0;
         r_flush_busy <= 1'b0;
         r_rd_count   <= '0;
      end else begin
         r_state      <= w_state_next;
         r_run        <= 1'b1;
         r_m_valid    <= (w_cnt_next != 2'd0) && (w_state_next != ST_FLUSH);
         r_flush_busy <= (w_state_next == ST_FLUSH);
         if (w_pop) begin
            r_rd_count <= r_rd_count + ONE_CW;
         end
      end
   end

   assign rinc       = w_rinc;
   assign m_data     = w_head;
   assign m_valid    = r_m_valid;
   assign flush_busy = r_flush_busy;
   assign rd_count   = r_rd_count;
   assign dbg_state  = r_state;

   a_no_rinc_when_empty : assert property (
      @(posedge rclk) disable iff (!rrst_n) !(rinc && rempty)
   );

endmodule

// File: tb/tb_fifo_rd_stream.sv
module tb_fifo_rd_stream;
  localparam int DSIZE = 8;
  localparam int CW    = 4;

  logic             rclk;
  logic             rrst_n;
  logic [DSIZE-1:0] rdata;
  logic             rempty;
  logic             rinc;
  logic [DSIZE-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  logic             flush;
  logic             flush_busy;
  logic [CW-1:0]    rd_count;
  logic [1:0]       dbg_state;

  int n_tests;
  int n_fail;
  int rinc_cnt;

  logic [DSIZE-1:0] fifo_q[$];
  logic [DSIZE-1:0] exp_q[$];

  fifo_rd_stream #(
    .DSIZE (DSIZE),
    .CW    (CW)
  ) dut (
    .rclk       (rclk),
    .rrst_n     (rrst_n),
    .rdata      (rdata),
    .rempty     (rempty),
    .rinc       (rinc),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .flush      (flush),
    .flush_busy (flush_busy),
    .rd_count   (rd_count),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void fifo_refresh();
    rempty = (fifo_q.size() == 0);
    rdata  = rempty ? '0 : fifo_q[0];
  endfunction

  task automatic load_word(input logic [DSIZE-1:0] w, input bit expect_it);
    fifo_q.push_back(w);
    if (expect_it) exp_q.push_back(w);
    fifo_refresh();
  endtask

  // inputs change 2 time units after the rising edge
  task automatic tick();
    @(posedge rclk);
    #2;
  endtask

  task automatic wait_drained(input string tag);
    int i;
    i = 0;
    while ((exp_q.size() != 0 || m_valid) && i < 40) begin
      tick();
      i++;
    end
    check(tag, (exp_q.size() != 0 || m_valid) ? 32'd1 : 32'd0, 32'd0);
  endtask

  // ---------------- FIFO model + stream scoreboard ----------------
  // Everything is sampled at the falling edge; the handshake or pop then
  // happens on the following rising edge.
  always begin
    bit v_pop;
    @(negedge rclk);
    v_pop = 1'b0;
    if (rrst_n) begin
      v_pop = rinc;
      if (rinc && rempty) check("rinc_while_empty", 32'd1, 32'd0);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", {24'd0, m_data}, 32'hFFFF_FFFF);
        end else begin
          check("stream_data", {24'd0, m_data}, {24'd0, exp_q.pop_front()});
        end
      end
    end
    @(posedge rclk);
    #1;
    if (v_pop && fifo_q.size() != 0) begin
      void'(fifo_q.pop_front());
      rinc_cnt++;
    end
    fifo_refresh();
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [DSIZE-1:0] w0;
    int i;
    n_tests  = 0;
    n_fail   = 0;
    rinc_cnt = 0;
    m_ready  = 1'b0;
    flush    = 1'b0;
    rrst_n   = 1'b1;
    fifo_refresh();
    #1 rrst_n = 1'b0;
    #1;
    check("rst_rinc", rinc, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_flush_busy", flush_busy, 0);
    check("rst_rd_count", rd_count, 0);
    check("rst_state", dbg_state, 0);
    tick();
    tick();
    rrst_n = 1'b1;

    // 1. idle with rempty=1
    for (int k = 0; k < 10; k++) begin
      tick();
      check("idle_rinc", rinc, 0);
      check("idle_m_valid", m_valid, 0);
      check("idle_rd_count", rd_count, 0);
    end

    // 2. preloaded 0x01..0x08, m_ready=1 throughout
    m_ready = 1'b1;
    for (int k = 1; k <= 8; k++) load_word(DSIZE'(k), 1'b1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("burst_valid", m_valid, 1);
      check("burst_data", m_data, k);
    end
    tick();
    check("burst_end_valid", m_valid, 0);
    check("burst_rd_count", rd_count, 8);
    m_ready = 1'b0;

    // 3. backpressure: five random words, m_ready=0
    rinc_cnt = 0;
    w0 = DSIZE'($urandom_range(0, 255));
    load_word(w0, 1'b1);
    for (int k = 1; k < 5; k++) load_word(DSIZE'($urandom_range(0, 255)), 1'b1);
    for (int k = 0; k < 6; k++) begin
      tick();
      check("bp_head_hold", m_data, w0);
      check("bp_valid", m_valid, 1);
    end
    check("bp_rinc_pulses", rinc_cnt, 2);
    check("bp_rinc_low", rinc, 0);
    check("bp_state_two", dbg_state, 2);
    check("bp_fifo_left", fifo_q.size(), 3);
    m_ready = 1'b1;
    wait_drained("bp_drain_timeout");
    m_ready = 1'b0;
    check("bp_rd_count", rd_count, 13);

    // 4. two buffered + four in FIFO, one-cycle flush
    for (int k = 0; k < 6; k++) load_word(DSIZE'(8'h40 + k), 1'b0);
    tick();
    tick();
    tick();
    check("fl_pre_fifo", fifo_q.size(), 4);
    check("fl_pre_valid", m_valid, 1);
    rinc_cnt = 0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_valid_drop", m_valid, 0);
    check("fl_busy", flush_busy, 1);
    i = 0;
    while (flush_busy && i < 20) begin
      tick();
      check("fl_valid_low", m_valid, 0);
      i++;
    end
    check("fl_busy_timeout", flush_busy, 0);
    check("fl_rinc_drained", rinc_cnt, 4);
    check("fl_fifo_empty", fifo_q.size(), 0);
    check("fl_rd_count", rd_count, 13);
    check("fl_state_empty", dbg_state, 0);

    // 5. flush on the same edge as the 0xAA handshake
    load_word(8'hAA, 1'b1);
    load_word(8'hBB, 1'b0);
    tick();
    tick();
    tick();
    check("fh_head", m_data, 8'hAA);
    check("fh_valid", m_valid, 1);
    m_ready = 1'b1;
    flush   = 1'b1;
    tick();
    flush = 1'b0;
    check("fh_rd_count", rd_count, 14);
    check("fh_valid_drop", m_valid, 0);
    check("fh_busy", flush_busy, 1);
    tick();
    check("fh_busy_clear", flush_busy, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("fh_no_bb", m_valid, 0);
    end
    check("fh_exp_empty", exp_q.size(), 0);

    // rd_count wrap: 14 + 3 = 17 -> 1 with CW=4
    for (int k = 0; k < 3; k++) load_word(DSIZE'(8'h70 + k), 1'b1);
    wait_drained("wrap_drain_timeout");
    check("wrap_rd_count", rd_count, 1);
    m_ready = 1'b0;

    // 6. async reset while in TWO
    load_word(8'h60, 1'b0);
    load_word(8'h61, 1'b0);
    load_word(8'h62, 1'b0);
    tick();
    tick();
    tick();
    check("ar_pre_valid", m_valid, 1);
    check("ar_pre_state", dbg_state, 2);
    rrst_n = 1'b0;
    #1;
    check("ar_m_valid", m_valid, 0);
    check("ar_m_data", m_data, 0);
    check("ar_rinc", rinc, 0);
    check("ar_rd_count", rd_count, 0);
    check("ar_flush_busy", flush_busy, 0);
    check("ar_state", dbg_state, 0);
    tick();
    rrst_n = 1'b1;
    exp_q.push_back(8'h62);
    i = 0;
    while (!m_valid && i < 10) begin
      tick();
      i++;
    end
    check("ar_first_word", m_data, 8'h62);
    m_ready = 1'b1;
    wait_drained("ar_drain_timeout");
    m_ready = 1'b0;
    check("ar_rd_count_after", rd_count, 1);
    check("ar_fifo_empty", fifo_q.size(), 0);

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
